// File: rtl/mux7_sel_scanner.sv
// Drives the 3-bit select of a 7-to-1 mux and captures the mux output for each input in turn.
// Steps on a divided-clock tick (auto) or on each step rising edge (single-step); synchronous load overrides.
module mux7_sel_scanner #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       step,
    input  logic       load,
    input  logic [2:0] load_sel,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [6:0] samples,
    output logic       sample_valid,
    output logic       sweep_done
);

    localparam int              CW     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   RELOAD = CW'(TICK_DIV - 1);
    localparam logic [2:0]      SEL_MAX = 3'd6;

    logic [CW-1:0] tick_cnt;
    logic          step_q;
    logic          tick;
    logic          step_rise;
    logic          adv;

    assign tick      = (tick_cnt == '0);
    assign step_rise = step & ~step_q;
    assign adv       = mode ? step_rise : tick;

    // Divider holds at full count in single-step mode so returning to auto restarts a whole period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= RELOAD;
        end else if (load || mode || tick) begin
            tick_cnt <= RELOAD;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // Capture uses the pre-advance sel, i.e. the mux input visible during the advancing cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel          <= 3'd0;
            samples      <= 7'd0;
            sample_valid <= 1'b0;
            sweep_done   <= 1'b0;
        end else if (load) begin
            sel          <= (load_sel == 3'd7) ? 3'd0 : load_sel;
            sample_valid <= 1'b0;
            sweep_done   <= 1'b0;
        end else if (adv) begin
            samples[sel] <= mux_out;
            sel          <= (sel == SEL_MAX) ? 3'd0 : sel + 3'd1;
            sample_valid <= 1'b1;
            sweep_done   <= (sel == SEL_MAX);
        end else begin
            sample_valid <= 1'b0;
            sweep_done   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux7_sel_scanner.sv
// Bench for mux7_sel_scanner: reference model checked every cycle plus directed literal checks.
module tb_mux7_sel_scanner;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode = 1'b0;
    logic       step = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_sel = 3'd0;
    logic       mux_out;
    logic [2:0] sel;
    logic [6:0] samples;
    logic       sample_valid;
    logic       sweep_done;

    logic [6:0] mux_data = 7'b1010011;
    assign mux_out = mux_data[sel];

    mux7_sel_scanner #(.TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .mode(mode), .step(step), .load(load),
        .load_sel(load_sel), .mux_out(mux_out), .sel(sel), .samples(samples),
        .sample_valid(sample_valid), .sweep_done(sweep_done)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    int sd_cnt = 0;
    int n;
    bit cmp_en = 1'b0;

    // Reference model: phase counts cycles elapsed in the current auto period.
    int         m_phase;
    int         m_sel;
    logic [6:0] m_samples;
    logic       m_sv, m_sd, m_step_prev;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_sel <= 0; m_samples <= '0;
            m_sv <= 1'b0; m_sd <= 1'b0; m_step_prev <= 1'b0;
        end else begin
            bit rise, do_adv;
            rise   = step && !m_step_prev;
            do_adv = mode ? rise : (m_phase == TD - 1);
            m_step_prev <= step;
            if (load) begin
                m_sel <= (load_sel == 3'd7) ? 0 : int'(load_sel);
                m_phase <= 0;
                m_sv <= 1'b0; m_sd <= 1'b0;
            end else begin
                m_phase <= mode ? 0 : (m_phase + 1) % TD;
                if (do_adv) begin
                    m_samples[m_sel] <= mux_data[m_sel];
                    m_sel <= (m_sel + 1) % 7;
                    m_sv <= 1'b1;
                    m_sd <= (m_sel == 6);
                end else begin
                    m_sv <= 1'b0; m_sd <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                check("model_sel", 32'(sel), 32'(m_sel));
                check("model_samples", 32'(samples), 32'(m_samples));
                check("model_sample_valid", 32'(sample_valid), 32'(m_sv));
                check("model_sweep_done", 32'(sweep_done), 32'(m_sd));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; mode = 1'b0; step = 1'b0; load = 1'b0; load_sel = 3'd0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Cycles (negedges) until a sample_valid pulse is seen, bounded.
    task automatic wait_adv(output int cycles);
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!sample_valid && cycles < 40);
        if (sweep_done) sd_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cmp_en = 1'b1;
        do_reset();
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_samples", 32'(samples), 32'd0);
        check("reset_pulses", 32'({sample_valid, sweep_done}), 32'd0);

        // Auto sweep of a full input pattern.
        mux_data = 7'b1010011;
        sd_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            wait_adv(n);
            check("auto_period", 32'(n), 32'(TD));
        end
        check("auto_samples", 32'(samples), 32'h53);
        check("auto_sel_wrap", 32'(sel), 32'd0);
        check("auto_sweep_once", 32'(sd_cnt), 32'd1);

        // Single-step: a held step gives exactly one advance.
        do_reset();
        mode = 1'b1;
        mux_data = 7'b0110101;
        step = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (sample_valid) n++;
        end
        step = 1'b0;
        check("held_step_pulses", 32'(n), 32'd1);
        check("held_step_sel", 32'(sel), 32'd1);
        sd_cnt = 0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            step = 1'b1;
            @(negedge clock);
            if (sweep_done) sd_cnt++;
            step = 1'b0;
            @(negedge clock);
            if (sweep_done) sd_cnt++;
        end
        check("step_sweep_once", 32'(sd_cnt), 32'd1);
        check("step_sel_wrap", 32'(sel), 32'd0);
        check("step_samples", 32'(samples), 32'h35);

        // Load in the tick cycle wins over the advance.
        do_reset();
        n = 0;
        while (m_phase != TD - 1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        load = 1'b1; load_sel = 3'd5;
        @(negedge clock);
        load = 1'b0;
        check("load_sel5", 32'(sel), 32'd5);
        check("load_no_pulse", 32'(sample_valid), 32'd0);
        check("load_samples_kept", 32'(samples), 32'd0);
        load = 1'b1; load_sel = 3'd7;
        @(negedge clock);
        load = 1'b0;
        check("load_sel7", 32'(sel), 32'd0);

        // Asynchronous reset mid-sweep.
        do_reset();
        mux_data = 7'b1111111;
        repeat (3) wait_adv(n);
        check("pre_reset_sel", 32'(sel), 32'd3);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_sel", 32'(sel), 32'd0);
        check("async_samples", 32'(samples), 32'd0);
        check("async_pulses", 32'({sample_valid, sweep_done}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        wait_adv(n);
        check("post_reset_first_adv", 32'(n), 32'(TD));

        // Mode 1 excursion restarts a full auto period.
        do_reset();
        n = 0;
        while (m_phase != TD - 2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        mode = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clock);
            if (sample_valid) n++;
        end
        check("mode1_no_adv", 32'(n), 32'd0);
        mode = 1'b0;
        wait_adv(n);
        check("mode_return_period", 32'(n), 32'(TD));

        // Stepping across the wrap point.
        do_reset();
        mode = 1'b1;
        mux_data = 7'b1000001;
        load = 1'b1; load_sel = 3'd6;
        @(negedge clock);
        load = 1'b0;
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        check("wrap_sel0", 32'(sel), 32'd0);
        check("wrap_sweep", 32'(sweep_done), 32'd1);
        check("wrap_sample6", 32'(samples), 32'h40);
        @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        check("wrap_sel1", 32'(sel), 32'd1);
        check("wrap_no_sweep", 32'(sweep_done), 32'd0);
        check("wrap_sample0", 32'(samples), 32'h41);
        @(negedge clock);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
